dmem_dump_arbiter: RTL and testbench

- Owns the data-memory BRAM port and shares it between the pipeline MEM stage and the debug unit.
- In normal run, the MEM stage drives the BRAM transparently.
- On a dump request from the debug unit, the block stalls the pipeline and walks addresses 0..DUMP_LAST, reading each word. It streams the words to the debug unit over a valid/ready handshake, then returns ownership to the pipeline.

---
 rtl/dmem_dbg_defs.sv | 21 ++
 rtl/dmem_port_mux.sv | 26 ++
 rtl/dmem_dump_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_dump_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_dbg_defs.sv
// Shared definitions for the data-memory dump logic: default widths,
// dump FSM state encoding and the address tag used for the checksum word.
// Optional feature macro: DMEM_DUMP_CHECKSUM_EN (checksum word after the data words).
package dmem_dbg_defs;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 8;

   // The checksum word is tagged with an all-ones address; this is the fill bit.
   localparam logic CSUM_ADDR_FILL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      SEND,
      CSUM,
      DONE
   } dump_state_t;

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational BRAM port select between the pipeline MEM stage and the
// dump walker. While the dump owns the port, writes are always suppressed.
module dmem_port_mux
   import dmem_dbg_defs::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              dump_sel,
   input  logic              pipe_we,
   input  logic [ADDR_W-1:0] pipe_addr,
   input  logic [DATA_W-1:0] pipe_wdata,
   input  logic [ADDR_W-1:0] dump_addr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata
);

   // Pass the pipeline straight through unless the dump walker owns the port.
   always_comb begin
      mem_we    = pipe_we & ~dump_sel;
      mem_addr  = dump_sel ? dump_addr : pipe_addr;
      mem_wdata = pipe_wdata;
   end

endmodule

// File: rtl/dmem_dump_arbiter.sv
// Data-memory port owner: transparent pipeline access in normal run, and on a
// debug request stalls the pipeline and streams addresses 0..DUMP_LAST out
// over a valid/ready handshake.
// Optional feature macro: DMEM_DUMP_CHECKSUM_EN appends an XOR checksum word
// (address all-ones) after the last data word.
module dmem_dump_arbiter
   import dmem_dbg_defs::*;
#(
   parameter int                DATA_W    = DEF_DATA_W,
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] DUMP_LAST = ADDR_W'(255),
   parameter int                ADDR_STEP = 1
) (
   input  logic              clk,
   input  logic              i_reset_n,
   input  logic              i_pipe_we,
   input  logic [ADDR_W-1:0] i_pipe_addr,
   input  logic [DATA_W-1:0] i_pipe_wdata,
   output logic [DATA_W-1:0] o_pipe_rdata,
   output logic              o_pipe_stall,
   input  logic              i_dump_start,
   output logic              o_dump_busy,
   output logic [DATA_W-1:0] o_dump_data,
   output logic [ADDR_W-1:0] o_dump_addr,
   output logic              o_dump_valid,
   input  logic              i_dump_ready,
   output logic              o_dump_done,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   dump_state_t       state;
   dump_state_t       state_nx;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W:0]   cnt_sum;
   logic              last_word;
   logic              accept;
   logic [DATA_W-1:0] dump_data_q;
   logic [ADDR_W-1:0] dump_addr_q;
`ifdef DMEM_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q;
`endif

   // One extra bit on the sum catches a step that would wrap past the top of
   // the address space; such a step also ends the dump.
   assign cnt_sum   = {1'b0, cnt} + (ADDR_W+1)'(ADDR_STEP);
   assign last_word = (cnt >= DUMP_LAST) || (cnt_sum > {1'b0, DUMP_LAST});
   assign accept    = (state == SEND) && i_dump_ready;

   assign o_pipe_rdata = i_mem_rdata;
   assign o_pipe_stall = (state != IDLE);
   assign o_dump_busy  = (state != IDLE);
   assign o_dump_valid = (state == SEND) || (state == CSUM);
   assign o_dump_done  = (state == DONE);
   assign o_dump_data  = dump_data_q;
   assign o_dump_addr  = dump_addr_q;

   dmem_port_mux #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_port_mux (
      .dump_sel  (state != IDLE),
      .pipe_we   (i_pipe_we),
      .pipe_addr (i_pipe_addr),
      .pipe_wdata(i_pipe_wdata),
      .dump_addr (cnt),
      .mem_we    (o_mem_we),
      .mem_addr  (o_mem_addr),
      .mem_wdata (o_mem_wdata)
   );

   // Next-state logic: issue, wait out BRAM latency, hold the word until accepted.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (i_dump_start) state_nx = ISSUE;
         ISSUE: state_nx = WAIT;
         WAIT:  state_nx = SEND;
         SEND: begin
            if (accept) begin
               if (last_word) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                  state_nx = CSUM;
`else
                  state_nx = DONE;
`endif
               end else begin
                  state_nx = ISSUE;
               end
            end
         end
         CSUM:  if (i_dump_ready) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register, address counter and the registered word presented to debug.
   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         dump_data_q <= '0;
         dump_addr_q <= '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (i_dump_start) begin
                  cnt <= '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
                  csum_q <= '0;
`endif
               end
            end
            WAIT: begin
               dump_data_q <= i_mem_rdata;
               dump_addr_q <= cnt;
            end
            SEND: begin
               if (accept) begin
                  if (!last_word) begin
                     cnt <= cnt_sum[ADDR_W-1:0];
                  end
`ifdef DMEM_DUMP_CHECKSUM_EN
                  csum_q <= csum_q ^ dump_data_q;
                  if (last_word) begin
                     dump_data_q <= csum_q ^ dump_data_q;
                     dump_addr_q <= {ADDR_W{CSUM_ADDR_FILL}};
                  end
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Self-checking bench for dmem_dump_arbiter with DUMP_LAST = 3 and a
// behavioural 1-cycle BRAM. Dumped words are checked by a scoreboard monitor.
// Optional feature macro: DMEM_DUMP_CHECKSUM_EN (adds the checksum word).
module tb_dmem_dump_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              pipe_we;
   logic [ADDR_W-1:0] pipe_addr;
   logic [DATA_W-1:0] pipe_wdata;
   logic [DATA_W-1:0] pipe_rdata;
   logic              pipe_stall;
   logic              dump_start;
   logic              dump_busy;
   logic [DATA_W-1:0] dump_data;
   logic [ADDR_W-1:0] dump_addr;
   logic              dump_valid;
   logic              dump_ready;
   logic              dump_done;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic [DATA_W-1:0] mem [256];

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
   } word_t;

   word_t sb_q[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_acc = -1;
   int done_cnt = 0;
   int iso_err = 0;
   bit gap_check = 1'b0;

   dmem_dump_arbiter #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DUMP_LAST(8'd3),
      .ADDR_STEP(1)
   ) dut (
      .clk         (clk),
      .i_reset_n   (reset_n),
      .i_pipe_we   (pipe_we),
      .i_pipe_addr (pipe_addr),
      .i_pipe_wdata(pipe_wdata),
      .o_pipe_rdata(pipe_rdata),
      .o_pipe_stall(pipe_stall),
      .i_dump_start(dump_start),
      .o_dump_busy (dump_busy),
      .o_dump_data (dump_data),
      .o_dump_addr (dump_addr),
      .o_dump_valid(dump_valid),
      .i_dump_ready(dump_ready),
      .o_dump_done (dump_done),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural BRAM: read-first, one cycle of read latency.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake, tracks done pulses and isolation.
   initial begin
      word_t exp_w;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (reset_n && dump_valid && dump_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_word: got data %h addr %h expected none", dump_data, dump_addr);
            end else begin
               exp_w = sb_q.pop_front();
               check_output("dump_data", dump_data, exp_w.data);
               check_output("dump_addr", {24'd0, dump_addr}, {24'd0, exp_w.addr});
            end
            if (gap_check && dump_addr != 8'hFF) begin
               if (last_acc >= 0) check_output("word_spacing", cyc - last_acc, 3);
               last_acc = cyc;
            end
         end
         if (dump_done) done_cnt++;
         if (dump_busy && mem_we) iso_err++;
      end
   end

   task automatic push_expected();
      for (int i = 0; i < 4; i++) sb_q.push_back('{data: 32'(i + 1), addr: 8'(i)});
`ifdef DMEM_DUMP_CHECKSUM_EN
      sb_q.push_back('{data: 32'h4, addr: 8'hFF});
`endif
   endtask

   task automatic run_dump(input bit bp, input bit inject);
      int  held = 0;
      bit  injected = 1'b0;
      bit  saw_done = 1'b0;
      int  done0;
      push_expected();
      gap_check = !bp;
      last_acc = -1;
      done0 = done_cnt;
      @(negedge clk);
      dump_start = 1'b1;
      dump_ready = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bp && dump_valid && dump_addr == 8'd2 && held < 5) begin
            dump_ready = 1'b0;
            held++;
            check_output("bp_valid", {31'd0, dump_valid}, 32'd1);
            check_output("bp_data", dump_data, 32'd3);
            check_output("bp_addr", {24'd0, dump_addr}, 32'd2);
         end else begin
            dump_ready = 1'b1;
         end
         if (inject) begin
            pipe_we    = 1'b1;
            pipe_addr  = 8'd0;
            pipe_wdata = 32'hBAD0BAD0;
            if (dump_valid && dump_addr == 8'd1 && !injected) begin
               dump_start = 1'b1;
               injected = 1'b1;
            end else begin
               dump_start = 1'b0;
            end
         end
         if (dump_done) begin
            saw_done = 1'b1;
            break;
         end
      end
      pipe_we = 1'b0;
      dump_start = 1'b0;
      if (!saw_done) begin
         checks++;
         errors++;
         $display("[TB] FAIL dump_timeout: got no done expected done pulse");
      end
      @(negedge clk);
      check_output("stall_after_done", {31'd0, pipe_stall}, 32'd0);
      check_output("busy_after_done", {31'd0, dump_busy}, 32'd0);
      repeat (20) @(negedge clk);
      check_output("done_pulses", done_cnt - done0, 1);
      check_output("sb_empty", sb_q.size(), 0);
      if (bp) check_output("bp_cycles", held, 5);
   endtask

   task automatic apply_stimulus();
      int done0;
      bit hit;
      // Reset state.
      reset_n = 1'b0; pipe_we = 1'b0; pipe_addr = '0; pipe_wdata = '0;
      dump_start = 1'b0; dump_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
      repeat (3) @(negedge clk);
      check_output("rst_stall", {31'd0, pipe_stall}, 32'd0);
      check_output("rst_busy", {31'd0, dump_busy}, 32'd0);
      check_output("rst_valid", {31'd0, dump_valid}, 32'd0);
      check_output("rst_done", {31'd0, dump_done}, 32'd0);
      check_output("rst_data", dump_data, 32'd0);
      check_output("rst_addr", {24'd0, dump_addr}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Pipeline passthrough write then read back.
      pipe_we = 1'b1; pipe_addr = 8'h10; pipe_wdata = 32'hDEADBEEF;
      #1;
      check_output("pt_we", {31'd0, mem_we}, 32'd1);
      check_output("pt_addr", {24'd0, mem_addr}, 32'h10);
      check_output("pt_wdata", mem_wdata, 32'hDEADBEEF);
      @(negedge clk);
      pipe_we = 1'b0; pipe_wdata = 32'h0;
      @(negedge clk);
      check_output("pt_rdata", pipe_rdata, 32'hDEADBEEF);

      // Full dump, ready high, with spacing checks.
      run_dump(1'b0, 1'b0);
      // Backpressure on word at address 2.
      run_dump(1'b1, 1'b0);
      // Pipeline writes and a second start during the dump.
      run_dump(1'b0, 1'b1);
      check_output("isolation", iso_err, 0);
      for (int i = 0; i < 4; i++) check_output("mem_intact", mem[i], 32'(i + 1));

      // Reset while word 2 is presented.
      push_expected();
      gap_check = 1'b0;
      done0 = done_cnt;
      hit = 1'b0;
      @(negedge clk);
      dump_start = 1'b1; dump_ready = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (dump_valid && dump_addr == 8'd2) begin
            dump_ready = 1'b0;
            reset_n = 1'b0;
            hit = 1'b1;
            break;
         end
      end
      check_output("reset_reached_word2", {31'd0, hit}, 32'd1);
      @(negedge clk);
      sb_q.delete();
      check_output("mid_rst_valid", {31'd0, dump_valid}, 32'd0);
      check_output("mid_rst_busy", {31'd0, dump_busy}, 32'd0);
      check_output("mid_rst_stall", {31'd0, pipe_stall}, 32'd0);
      check_output("mid_rst_data", dump_data, 32'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check_output("mid_rst_no_done", done_cnt - done0, 0);
      run_dump(1'b0, 1'b0);
   endtask

   initial begin
      apply_stimulus();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
